// File: rtl/uart_pkg.sv
// Shared types and limits for the parametrised UART transmitter.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // The unused encoding 2'b11 is deliberately folded into "no parity".
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write channel from a word producer into the UART TX FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) wide, so incrementing wraps modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable width, per-frame parity/stop settings and a TX FIFO.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 s_if,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          data_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS out of range");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_if.s_valid & ~fifo_full),
        .pop   (fifo_pop),
        .wdata (s_if.s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign s_if.s_ready = ~fifo_full;

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    parity_e              par_mode_q, par_mode_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 data_tx_q, data_tx_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 baud_last;

    assign baud_last = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        fifo_pop   = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_d    = ST_START;
                    baud_cnt_d = '0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d    = (par_mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase

        // Frame settings are captured with the word so mid-frame cfg changes wait.
        if (fifo_pop) begin
            shift_d    = fifo_rdata;
            par_mode_d = decode_parity(cfg_parity);
            par_bit_d  = (decode_parity(cfg_parity) == PAR_ODD) ? ~(^fifo_rdata) : ^fifo_rdata;
            stop2_d    = cfg_stop2;
        end

        case (state_d)
            ST_START:  data_tx_d = 1'b0;
            ST_DATA:   data_tx_d = shift_d[0];
            ST_PARITY: data_tx_d = par_bit_d;
            default:   data_tx_d = 1'b1;
        endcase
        tx_busy_d = (state_d != ST_IDLE);
        tx_done_d = (state_d == ST_STOP) &&
                    (baud_cnt_d == CNT_W'(CLKS_PER_BIT - 1)) &&
                    (stop_cnt_d == stop2_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            data_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            data_tx_q  <= data_tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign data_tx = data_tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo, checked against a frame-level line model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          data_tx;
    logic          tx_busy;
    logic          tx_done;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(DB)) s_if ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_if       (s_if),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .data_tx    (data_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [DB-1:0] data;
        logic [1:0]    mode;
        logic          stop2;
    } frame_t;

    int            checks   = 0;
    int            failures = 0;
    int            pushed   = 0;
    frame_t        exp_q[$];
    logic [DB-1:0] push_q[$];
    logic [2:0]    exp_sig[$];
    int            exp_starts[$];
    logic [2:0]    obs_sig[$];
    int            obs_cnt[$];
    logic          obs_rdy[$];
    int            obs_pushed[$];

    // Line model: frame as a list of bit periods, straight from the frame format.
    function automatic bit has_parity(frame_t f);
        return (f.mode == 2'b01) || (f.mode == 2'b10);
    endfunction

    function automatic int frame_len(frame_t f);
        return CPB * (1 + DB + (has_parity(f) ? 1 : 0) + (f.stop2 ? 2 : 1));
    endfunction

    function automatic logic line_bit(frame_t f, int c);
        int b;
        b = c / CPB;
        if (b == 0) return 1'b0;
        if (b <= DB) return f.data[b-1];
        if (has_parity(f) && b == DB + 1) return (f.mode == 2'b10) ? ~(^f.data) : ^f.data;
        return 1'b1;
    endfunction

    function automatic frame_t mk(input logic [DB-1:0] d, input logic [1:0] m, input logic s2);
        frame_t f;
        f.data = d; f.mode = m; f.stop2 = s2;
        return f;
    endfunction

    // Expected {tx_busy, tx_done, data_tx}: one idle lead cycle, frames, one idle tail.
    task automatic build_expected();
        int len;
        exp_sig.delete();
        exp_starts.delete();
        exp_sig.push_back(3'b001);
        foreach (exp_q[f]) begin
            len = frame_len(exp_q[f]);
            exp_starts.push_back(exp_sig.size());
            for (int c = 0; c < len; c++)
                exp_sig.push_back({1'b1, (c == len - 1), line_bit(exp_q[f], c)});
        end
        exp_sig.push_back(3'b001);
    endtask

    task automatic push_all();
        int   waited;
        logic acc;
        while (push_q.size() > 0) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = push_q[0];
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 3000) begin
                acc = s_if.s_ready;
                @(posedge clk);
                if (acc) pushed++;
                #1;
                waited++;
            end
            checks++;
            if (!acc) begin
                failures++;
                $display("[TB] FAIL push_timeout s_ready got=0 exp=1");
                push_q.delete();
            end else begin
                void'(push_q.pop_front());
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_data  = DB'($urandom);
    endtask

    task automatic capture(input int n);
        obs_sig.delete(); obs_cnt.delete(); obs_rdy.delete(); obs_pushed.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
            obs_sig.push_back({tx_busy, tx_done, data_tx});
            obs_cnt.push_back(int'(fifo_count));
            obs_rdy.push_back(s_if.s_ready);
            obs_pushed.push_back(pushed);
        end
    endtask

    task automatic run_stream();
        foreach (exp_q[i]) push_q.push_back(exp_q[i].data);
        build_expected();
        pushed = 0;
        fork
            push_all();
            capture(exp_sig.size());
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 5;
        if (data_tx !== 1'b1)    begin failures++; $display("[TB] FAIL reset_data_tx got=%b exp=1", data_tx); end
        if (tx_busy !== 1'b0)    begin failures++; $display("[TB] FAIL reset_tx_busy got=%b exp=0", tx_busy); end
        if (tx_done !== 1'b0)    begin failures++; $display("[TB] FAIL reset_tx_done got=%b exp=0", tx_done); end
        if (s_if.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready got=%b exp=1", s_if.s_ready); end
        if (fifo_count !== '0)   begin failures++; $display("[TB] FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_8n1();
        int dones;
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        exp_q = '{mk(8'h55, 2'b00, 1'b0)};
        run_stream();
        dones = 0;
        foreach (exp_sig[i]) begin
            checks++;
            if (obs_sig[i] !== exp_sig[i]) begin
                failures++;
                $display("[TB] FAIL 8n1_line cyc=%0d {busy,done,tx} got=%b exp=%b", i, obs_sig[i], exp_sig[i]);
            end
            if (obs_sig[i][1]) dones++;
        end
        checks += 2;
        if (dones !== 1) begin failures++; $display("[TB] FAIL 8n1_done_count got=%0d exp=1", dones); end
        if (obs_sig[40][1] !== 1'b1) begin failures++; $display("[TB] FAIL 8n1_done_at_40 got=%b exp=1", obs_sig[40][1]); end
    endtask

    task automatic test_parity();
        int done_at;
        int want;
        for (int m = 1; m <= 3; m++) begin
            cfg_parity = 2'(m); cfg_stop2 = 1'b0;
            exp_q = '{mk(8'h07, 2'(m), 1'b0)};
            run_stream();
            done_at = -1;
            foreach (exp_sig[i]) begin
                checks++;
                if (obs_sig[i] !== exp_sig[i]) begin
                    failures++;
                    $display("[TB] FAIL parity_line mode=%0d cyc=%0d {busy,done,tx} got=%b exp=%b", m, i, obs_sig[i], exp_sig[i]);
                end
                if (obs_sig[i][1] && done_at < 0) done_at = i;
            end
            want = (m == 3) ? 40 : 44;
            checks++;
            if (done_at !== want) begin
                failures++;
                $display("[TB] FAIL parity_frame_len mode=%0d got=%0d exp=%0d", m, done_at, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] second;
        second = DB'($urandom);
        cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        exp_q = '{mk(8'hA3, 2'b00, 1'b1), mk(second, 2'b00, 1'b1)};
        run_stream();
        foreach (exp_sig[i]) begin
            checks++;
            if (obs_sig[i] !== exp_sig[i]) begin
                failures++;
                $display("[TB] FAIL b2b_line cyc=%0d {busy,done,tx} got=%b exp=%b", i, obs_sig[i], exp_sig[i]);
            end
        end
        cfg_stop2 = 1'b0;
    endtask

    task automatic test_burst();
        int starts, exp_cnt, dones;
        bit saw_full;
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        exp_q.delete();
        for (int w = 0; w < 20; w++) exp_q.push_back(mk(DB'(w), 2'b00, 1'b0));
        run_stream();
        dones = 0; saw_full = 0;
        foreach (exp_sig[i]) begin
            starts = 0;
            foreach (exp_starts[j]) if (exp_starts[j] <= i) starts++;
            exp_cnt = obs_pushed[i] - starts;
            if (exp_cnt == DEPTH) saw_full = 1;
            checks += 3;
            if (obs_sig[i] !== exp_sig[i]) begin
                failures++;
                $display("[TB] FAIL burst_line cyc=%0d {busy,done,tx} got=%b exp=%b", i, obs_sig[i], exp_sig[i]);
            end
            if (obs_cnt[i] !== exp_cnt) begin
                failures++;
                $display("[TB] FAIL burst_count cyc=%0d got=%0d exp=%0d", i, obs_cnt[i], exp_cnt);
            end
            if (obs_rdy[i] !== (exp_cnt != DEPTH)) begin
                failures++;
                $display("[TB] FAIL burst_s_ready cyc=%0d got=%b exp=%b", i, obs_rdy[i], (exp_cnt != DEPTH));
            end
            if (obs_sig[i][1]) dones++;
        end
        checks += 2;
        if (dones !== 20) begin failures++; $display("[TB] FAIL burst_done_count got=%0d exp=20", dones); end
        if (!saw_full) begin failures++; $display("[TB] FAIL burst_reached_full got=0 exp=1"); end
    endtask

    task automatic test_random_frames();
        int nw;
        logic [1:0] m;
        logic s2;
        for (int it = 0; it < 6; it++) begin
            m  = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            cfg_parity = m; cfg_stop2 = s2;
            exp_q.delete();
            for (int w = 0; w < nw; w++) exp_q.push_back(mk(DB'($urandom), m, s2));
            run_stream();
            foreach (exp_sig[i]) begin
                checks++;
                if (obs_sig[i] !== exp_sig[i]) begin
                    failures++;
                    $display("[TB] FAIL random_line it=%0d cyc=%0d {busy,done,tx} got=%b exp=%b", it, i, obs_sig[i], exp_sig[i]);
                end
            end
        end
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    endtask

    task automatic test_cfg_mid_frame();
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        exp_q = '{mk(8'hFF, 2'b00, 1'b0), mk(8'hFF, 2'b01, 1'b0)};
        fork
            run_stream();
            begin
                repeat (12) @(posedge clk);
                #2;
                cfg_parity = 2'b01;
            end
        join
        foreach (exp_sig[i]) begin
            checks++;
            if (obs_sig[i] !== exp_sig[i]) begin
                failures++;
                $display("[TB] FAIL cfg_mid_line cyc=%0d {busy,done,tx} got=%b exp=%b", i, obs_sig[i], exp_sig[i]);
            end
        end
        cfg_parity = 2'b00;
    endtask

    task automatic test_reset_mid_frame();
        bit saw_low, saw_done, saw_busy;
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push_q = '{8'h3C, 8'h81, 8'hE7};
        push_all();
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 5;
        if (data_tx !== 1'b1)      begin failures++; $display("[TB] FAIL rstmid_data_tx got=%b exp=1", data_tx); end
        if (tx_busy !== 1'b0)      begin failures++; $display("[TB] FAIL rstmid_tx_busy got=%b exp=0", tx_busy); end
        if (tx_done !== 1'b0)      begin failures++; $display("[TB] FAIL rstmid_tx_done got=%b exp=0", tx_done); end
        if (fifo_count !== '0)     begin failures++; $display("[TB] FAIL rstmid_fifo_count got=%0d exp=0", fifo_count); end
        if (s_if.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_s_ready got=%b exp=1", s_if.s_ready); end
        saw_low = 0; saw_done = 0; saw_busy = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (data_tx !== 1'b1) saw_low  = 1;
            if (tx_done !== 1'b0) saw_done = 1;
            if (tx_busy !== 1'b0) saw_busy = 1;
        end
        checks += 3;
        if (saw_low)  begin failures++; $display("[TB] FAIL rstmid_line_quiet got=active exp=idle"); end
        if (saw_done) begin failures++; $display("[TB] FAIL rstmid_no_done got=1 exp=0"); end
        if (saw_busy) begin failures++; $display("[TB] FAIL rstmid_not_busy got=1 exp=0"); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete got=timeout exp=done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_burst();
        test_random_frames();
        test_cfg_mid_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the current fixed 8N1 transmitter. It adds a configurable data width, a runtime-selectable parity mode and 1 or 2 stop bits. A synchronous TX FIFO with a valid/ready write side allows back-to-back frames with no idle gap. It sits between any byte producer and the serial line, and its frame format is compatible with the team's UART receiver.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  producer has a word on s_data.
- s_ready  out  1  FIFO can accept a word (not full).
- s_data  in  DATA_BITS  word to transmit; bit 0 is sent first.
- cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- data_tx  out  1  serial line; idle level is high.
- tx_busy  out  1  FSM is not in IDLE.
- tx_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words currently stored.

Behaviour:
- Reset (rst=1 at a rising edge) sets outputs from the next cycle:
  - data_tx=1, tx_busy=0, tx_done=0, s_ready=1, fifo_count=0.
  - FIFO pointers, bit and baud counters and the shift register are cleared.
  - A frame in progress is abandoned; no partial stop bit is sent.
- Write handshake:
  - A word is pushed on an edge where s_valid && s_ready.
  - s_ready = (fifo_count != FIFO_DEPTH); it depends only on the count, not on a same-cycle pop.
  - s_data may change freely when no push occurs.
- FIFO:
  - First-in first-out ordering.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop is never issued when the FIFO is empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: data_tx=1. If the FIFO is non-empty, pop the head word and latch it together with cfg_parity and cfg_stop2 into frame registers, then go to START.
  - START: data_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out DATA_BITS bits LSB first, CLKS_PER_BIT cycles each. Then go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: one bit. Even mode sends the XOR of the data bits; odd mode sends the inverse of that XOR. Then STOP.
  - STOP: data_tx=1 for 1 or 2 bit periods. On its final cycle tx_done=1. Next state is START (popping the next word the same edge) if the FIFO is non-empty, otherwise IDLE.
- Latency: a word pushed into an empty FIFO while the FSM is IDLE at edge N is popped at edge N+1; data_tx is low from edge N+1.
- Frame length is exactly CLKS_PER_BIT*(1+DATA_BITS+P+S) cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames have zero idle cycles between them.
- Configuration is latched per frame. Changes to cfg_* mid-frame affect only later frames.
- Baud counter runs 0..CLKS_PER_BIT-1 and restarts at every bit boundary.
- data_tx, tx_busy and tx_done are registered outputs.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - tx_state_e enum;
  - localparam DATA_BITS_MIN=5 and DATA_BITS_MAX=9 for elaboration-time checks.
- Sub-module uart_sync_fifo (parameters WIDTH and DEPTH):
  - ports push, pop, wdata, rdata, full, empty, count;
  - rdata is first-word-fall-through.

Test Plan:
- 8N1, 0x55 (CLKS_PER_BIT=4, DATA_BITS=8, parity none, 1 stop): data_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. Frame is 40 cycles; tx_done pulses once at cycle 40 and tx_busy is low afterwards.
- Parity, 0x07:
  - even mode: parity bit = 1, frame 44 cycles;
  - odd mode: parity bit = 0.
  - Parity mode 11 produces a frame identical to mode none.
- Two stop bits, 0xA3: data_tx is high for 8 cycles after the last data bit; the next START begins immediately when a second word is queued.
- Burst: push 20 words 0x00..0x13 on consecutive cycles with FIFO_DEPTH=16.
  - s_ready falls when fifo_count reaches 16 and rises after the next pop.
  - All 20 words appear on the line in order with no idle gap between frames.
  - Exactly 20 tx_done pulses occur.
- Mid-frame configuration change: start 0xFF with parity none, then switch cfg_parity to even during DATA. The current frame has no parity bit; the next queued 0xFF carries parity bit 0.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3 with 2 words queued.
  - data_tx=1, tx_busy=0 and fifo_count=0 on the next cycle.
  - No further frames are sent, and tx_done never pulses for the aborted frame.
